// File: rtl/sent_rx_frame_apb_if.sv
// sent_rx_frame_apb_if: APB slave bus bundle for the SENT frame receiver.
interface sent_rx_frame_apb_if;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PWRITE;
  logic       PSELx;
  logic       PENABLE;
  logic       PREADY;
  modport master (output PADDR, PWDATA, PWRITE, PSELx, PENABLE, input PRDATA, PREADY);
  modport slave  (input PADDR, PWDATA, PWRITE, PSELx, PENABLE, output PRDATA, PREADY);
endinterface

// File: rtl/sent_rx_frame_apb.sv
// sent_rx_frame_apb: SENT frame assembler with CRC4 check, 4-deep frame FIFO and APB readout.
// Define SENT_RX_CRC_EN to enable CRC checking; otherwise every complete frame is stored.
module sent_rx_frame_apb (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       nibble_valid,
  input  logic [3:0] nibble_in,
  input  logic       sync_pulse,
  input  logic       pause_pulse,
  sent_rx_frame_apb_if.slave apb,
  output logic       frame_irq
);
`ifdef SENT_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  // J2716 CRC table, entry i at bits [4i+3:4i]
  localparam logic [63:0] TAB = 64'h582FB6C1493EA7D0;
  typedef enum logic [1:0] {IDLE, STAT, DATA, CRC} state_t;
  state_t      state;
  logic [3:0]  status, crc;
  logic [23:0] data;
  logic [2:0]  cnt;
  logic        push_q;
  logic [27:0] frame_q;
  logic [27:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  level;
  logic        frame_err, crc_err, overflow;
  logic        rd_acc, wr_acc, empty, full, pop, push_ok, crc_ok, clr;
  logic        frame_err_set, crc_err_set, ovf_set;
  logic [3:0]  crc_tab;
  logic [27:0] head;
  logic [7:0]  status_reg;
  logic        unused;
  assign unused        = ^{pause_pulse, apb.PWDATA[4:0]};
  assign rd_acc        = apb.PSELx & apb.PENABLE & ~apb.PWRITE;
  assign wr_acc        = apb.PSELx & apb.PENABLE & apb.PWRITE;
  assign empty         = level == 3'd0;
  assign full          = level[2];
  assign pop           = rd_acc && apb.PADDR == 4'h4 && !empty;
  assign push_ok       = push_q && (!full || pop);
  assign crc_tab       = TAB[{crc, 2'b00} +: 4];
  assign crc_ok        = !CRC_EN || nibble_in == crc_tab;
  assign clr           = wr_acc && apb.PADDR == 4'h0;
  assign frame_err_set = sync_pulse && state != IDLE;
  assign crc_err_set   = !sync_pulse && nibble_valid && state == CRC && !crc_ok;
  assign ovf_set       = push_q && full && !pop;
  assign head          = empty ? 28'h0 : mem[rd_ptr];
  assign status_reg    = {frame_err, crc_err, overflow, full, empty, level};
  assign frame_irq     = !empty;
  assign apb.PREADY    = 1'b1;
  always_comb begin
    apb.PRDATA = !rd_acc ? 8'h00 :
                 apb.PADDR == 4'h0 ? status_reg :
                 apb.PADDR == 4'h1 ? {4'h0, head[27:24]} :
                 apb.PADDR == 4'h2 ? head[7:0] :
                 apb.PADDR == 4'h3 ? head[15:8] :
                 apb.PADDR == 4'h4 ? head[23:16] : 8'h00;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      status  <= 4'h0;
      data    <= 24'h0;
      crc     <= 4'h5;
      cnt     <= 3'd0;
      push_q  <= 1'b0;
      frame_q <= 28'h0;
    end else begin
      push_q <= 1'b0;
      if (sync_pulse) begin
        state <= STAT;
        cnt   <= 3'd0;
        crc   <= 4'h5;
      end else if (nibble_valid) begin
        case (state)
          STAT: begin
            status <= nibble_in;
            state  <= DATA;
          end
          DATA: begin
            data  <= {data[19:0], nibble_in};
            crc   <= nibble_in ^ crc_tab;
            cnt   <= cnt + 3'd1;
            state <= cnt == 3'd5 ? CRC : DATA;
          end
          CRC: begin
            state   <= IDLE;
            push_q  <= crc_ok;
            frame_q <= {status, data};
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      level     <= 3'd0;
      frame_err <= 1'b0;
      crc_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + {1'b0, push_ok};
      rd_ptr    <= rd_ptr + {1'b0, pop};
      level     <= level + {2'b0, push_ok} - {2'b0, pop};
      frame_err <= frame_err_set | (frame_err & ~(clr & apb.PWDATA[7]));
      crc_err   <= crc_err_set | (crc_err & ~(clr & apb.PWDATA[6]));
      overflow  <= ovf_set | (overflow & ~(clr & apb.PWDATA[5]));
    end
  end
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= frame_q;
  end
endmodule

// File: tb/tb_sent_rx_frame_apb.sv
// tb_sent_rx_frame_apb: directed self-checking bench for sent_rx_frame_apb.
module tb_sent_rx_frame_apb;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       nibble_valid = 1'b0;
  logic [3:0] nibble_in = 4'h0;
  logic       sync_pulse = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       frame_irq;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rd;
  sent_rx_frame_apb_if apb ();
  sent_rx_frame_apb dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .nibble_valid(nibble_valid), .nibble_in(nibble_in),
    .sync_pulse(sync_pulse), .pause_pulse(pause_pulse), .apb(apb.slave), .frame_irq(frame_irq)
  );
  always #5 PCLK = ~PCLK;
  function automatic logic [3:0] crc4(input logic [23:0] d);
    logic [3:0] t [16];
    logic [3:0] c;
    t = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4, 4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};
    c = 4'h5;
    for (int i = 5; i >= 0; i--) c = d[i*4 +: 4] ^ t[c];
    return t[c];
  endfunction
  task automatic send_nib(input logic [3:0] n);
    nibble_valid = 1'b1;
    nibble_in = n;
    @(negedge PCLK);
    nibble_valid = 1'b0;
  endtask
  task automatic send_sync();
    sync_pulse = 1'b1;
    @(negedge PCLK);
    sync_pulse = 1'b0;
  endtask
  task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] c);
    send_sync();
    send_nib(st);
    for (int i = 5; i >= 0; i--) send_nib(d[i*4 +: 4]);
    send_nib(c);
    @(negedge PCLK);
    @(negedge PCLK);
  endtask
  task automatic apb_read(input logic [3:0] a, output logic [7:0] d);
    apb.PSELx = 1'b1;
    apb.PWRITE = 1'b0;
    apb.PADDR = a;
    apb.PENABLE = 1'b0;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    @(negedge PCLK);
    apb.PSELx = 1'b0;
    apb.PENABLE = 1'b0;
  endtask
  task automatic apb_write(input logic [3:0] a, input logic [7:0] d);
    apb.PSELx = 1'b1;
    apb.PWRITE = 1'b1;
    apb.PADDR = a;
    apb.PWDATA = d;
    apb.PENABLE = 1'b0;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    apb.PSELx = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0;
  endtask
  task automatic test_reset();
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL reset_status got %h want 08", rd); end
    checks++; if (apb.PREADY !== 1'b1) begin errors++; $display("FAIL reset_pready got %b want 1", apb.PREADY); end
    checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", frame_irq); end
  endtask
  task automatic test_zero_frame();
    send_nib(4'h9);
    pause_pulse = 1'b1;
    send_frame(4'h3, 24'h000000, 4'h5);
    pause_pulse = 1'b0;
    checks++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL zero_irq got %b want 1", frame_irq); end
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL zero_status got %h want 01", rd); end
    apb_read(4'h1, rd);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL zero_r1 got %h want 03", rd); end
    apb_read(4'h2, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL zero_r2 got %h want 00", rd); end
    apb_read(4'h3, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL zero_r3 got %h want 00", rd); end
    apb_read(4'h4, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL zero_r4 got %h want 00", rd); end
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL zero_popped got %h want 08", rd); end
  endtask
  task automatic test_crc();
    send_frame(4'hA, 24'h123456, 4'h2);
    apb_read(4'h1, rd);
    checks++; if (rd !== 8'h0A) begin errors++; $display("FAIL crc_r1 got %h want 0a", rd); end
    apb_read(4'h2, rd);
    checks++; if (rd !== 8'h56) begin errors++; $display("FAIL crc_r2 got %h want 56", rd); end
    apb_read(4'h3, rd);
    checks++; if (rd !== 8'h34) begin errors++; $display("FAIL crc_r3 got %h want 34", rd); end
    apb_read(4'h4, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL crc_r4 got %h want 12", rd); end
    send_frame(4'hA, 24'h123456, 4'h3);
    apb_read(4'h0, rd);
`ifdef SENT_RX_CRC_EN
    checks++; if (rd !== 8'h48) begin errors++; $display("FAIL crc_bad_status got %h want 48", rd); end
`else
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL crc_off_status got %h want 01", rd); end
    apb_read(4'h4, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL crc_off_r4 got %h want 12", rd); end
`endif
    apb_write(4'h0, 8'hE0);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL crc_clear got %h want 08", rd); end
  endtask
  task automatic test_abort();
    send_sync();
    send_nib(4'h1);
    send_nib(4'hF);
    send_nib(4'hE);
    send_nib(4'hD);
    send_frame(4'h7, 24'h123456, 4'h2);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h81) begin errors++; $display("FAIL abort_status got %h want 81", rd); end
    apb_read(4'h1, rd);
    checks++; if (rd !== 8'h07) begin errors++; $display("FAIL abort_r1 got %h want 07", rd); end
    apb_read(4'h4, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL abort_r4 got %h want 12", rd); end
    apb_write(4'h0, 8'hE0);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL abort_clear got %h want 08", rd); end
  endtask
  task automatic test_overflow();
    logic [23:0] d;
    for (int i = 1; i <= 5; i++) begin
      d = {6{i[3:0]}};
      send_frame(i[3:0], d, crc4(d));
    end
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h34) begin errors++; $display("FAIL ovf_status got %h want 34", rd); end
    for (int i = 1; i <= 4; i++) begin
      apb_read(4'h4, rd);
      checks++; if (rd !== {i[3:0], i[3:0]}) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, rd, {i[3:0], i[3:0]}); end
    end
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h28) begin errors++; $display("FAIL ovf_drained got %h want 28", rd); end
    apb_write(4'h0, 8'hE0);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL ovf_clear got %h want 08", rd); end
  endtask
  task automatic test_reset_mid();
    send_frame(4'h1, 24'h000000, 4'h5);
    send_frame(4'h2, 24'h123456, 4'h2);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL rmid_pre got %h want 02", rd); end
    send_sync();
    send_nib(4'h4);
    send_nib(4'h1);
    send_nib(4'h2);
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL rmid_irq got %b want 0", frame_irq); end
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", dut.state); end
    @(negedge PCLK);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL rmid_status got %h want 08", rd); end
    PRESETn = 1'b1;
    @(negedge PCLK);
    send_frame(4'h6, 24'h000000, 4'h5);
    apb_read(4'h0, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL rmid_after got %h want 01", rd); end
    apb_read(4'h1, rd);
    checks++; if (rd !== 8'h06) begin errors++; $display("FAIL rmid_r1 got %h want 06", rd); end
  endtask
  initial begin
    apb.PADDR = 4'h0;
    apb.PWDATA = 8'h00;
    apb.PWRITE = 1'b0;
    apb.PSELx = 1'b0;
    apb.PENABLE = 1'b0;
    repeat (3) @(negedge PCLK);
    test_reset();
    PRESETn = 1'b1;
    @(negedge PCLK);
    test_zero_frame();
    test_crc();
    test_abort();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sent_rx_frame_apb.md
SENT_RX_FRAME_APB -- requirements
Module: sent_rx_frame_apb

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: PCLK in 1, APB/system clock, all logic on rising edge; PRESETn in 1, active-low asynchronous reset.
REQ-002 SHALL have input nibble_valid (1 bit): one-cycle strobe, decoded nibble present.
REQ-003 SHALL have input nibble_in (4 bits): decoded SENT nibble value, sampled when nibble_valid=1.
REQ-004 SHALL have input sync_pulse (1 bit): one-cycle strobe, sync pulse detected, start of frame.
REQ-005 SHALL have input pause_pulse (1 bit): one-cycle strobe, optional pause pulse detected.
REQ-006 SHALL have APB inputs PADDR (4 bits), PWDATA (8 bits), PWRITE (1), PSELx (1), PENABLE (1), with standard APB meanings.
REQ-007 SHALL have APB outputs PRDATA (8 bits, read data) and PREADY (1 bit, tied 1, zero wait states).
REQ-008 SHALL have output frame_irq (1 bit): high while the FIFO is not empty.

Function
REQ-009 SHALL run a frame FSM with states IDLE, STAT, DATA, CRC.
REQ-010 IDLE->STAT on sync_pulse; STAT->DATA on the first nibble_valid, which is latched as the status nibble; DATA collects 6 nibbles, first received nibble in data[23:20], last in data[3:0]; DATA->CRC after the 6th nibble; CRC->IDLE on the next nibble_valid.
REQ-011 CRC4 SHALL be computed per SAE J2716 (seed 4'h5, poly x^4+x^3+x^2+1, table 0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5): for each data nibble, c = n XOR T[c]; then a final zero-augment step, c = T[c]; the status nibble is excluded.
REQ-012 On CRC nibble == computed c, the frame {status[3:0], data[23:0]} SHALL be pushed into the FIFO in the cycle after the CRC nibble is accepted; on mismatch, no push and crc_err set.
REQ-013 sync_pulse in STAT, DATA or CRC SHALL abort the partial frame, set frame_err and restart in STAT; nibble_valid in IDLE SHALL be ignored.
REQ-014 pause_pulse SHALL be ignored in every state.
REQ-015 FIFO SHALL be 4 entries x 28 bits; level 0..4.
REQ-016 Push to a full FIFO without a simultaneous pop SHALL drop the new frame and set overflow; push and pop in the same cycle SHALL both take effect with level unchanged.
REQ-017 Register map: 0x0 STATUS = {frame_err, crc_err, overflow, full, empty, level[2:0]}, MSB first; 0x1 = {4'h0, status nibble}; 0x2 = data[7:0]; 0x3 = data[15:8]; 0x4 = data[23:16]; all other addresses read 8'h00.
REQ-018 Reads of 0x1-0x4 SHALL return the FIFO head, or 8'h00 when empty; an APB read access phase (PSELx & PENABLE & !PWRITE) at 0x4 with the FIFO not empty SHALL pop one entry.
REQ-019 An APB write to 0x0 SHALL clear each sticky bit [7:5] whose PWDATA bit is 1; a set event in the same cycle SHALL win over the clear. Writes to other addresses SHALL be ignored.
REQ-020 PRDATA SHALL be combinational from PADDR and the registers during a read access.

Reset
REQ-021 PRESETn=0 SHALL asynchronously force FSM=IDLE, FIFO empty (level 0, pointers 0), sticky bits 0, frame_err/crc_err/overflow 0, frame_irq 0, and discard any partial frame.
REQ-022 After reset: STATUS reads 8'h08, PREADY=1.

Configuration
REQ-023 Macro SENT_RX_CRC_EN: when defined, CRC checking follows REQ-011/012; when undefined, the CRC nibble is consumed without a check, every complete frame is pushed, and crc_err stays 0.

Verification
REQ-024 Frame sync, status 4'h3, data 0,0,0,0,0,0, CRC 5 -> push; 0x1=8'h03, 0x2/0x3/0x4=8'h00, STATUS=8'h01.
REQ-025 Frame with data 1,2,3,4,5,6 and CRC 2 -> 0x4=8'h12, 0x3=8'h34, 0x2=8'h56; same frame with CRC 3 -> no push, STATUS bit6=1 (SENT_RX_CRC_EN defined); with the macro undefined -> pushed.
REQ-026 Sync after 3 data nibbles, then a full valid frame -> only the second frame is stored, frame_err=1, level 1.
REQ-027 Five valid frames with no reads -> level 4, full=1, overflow=1, STATUS=8'h34; four reads of 0x4 -> values returned in order, then empty; write 8'hE0 to 0x0 -> STATUS=8'h08.
REQ-028 Assert PRESETn=0 mid-DATA with the FIFO holding 2 frames -> STATUS=8'h08 immediately, FSM in IDLE, a subsequent valid frame is received correctly.
